// File: rtl/acq_pkg.sv
// Shared types and constants for the acquisition framer.
package acq_pkg;

  // Default first header word.
  localparam logic [15:0] HDR_SYNC_DEF = 16'hA55A;

  // Header is sync word, sequence number, length.
  localparam int unsigned HDR_WORDS = 3;

  typedef enum logic [2:0] {
    StIdle,
    StHdr,
    StDelay,
    StCapture,
    StTrail
  } acq_state_e;

  // Frame checksum accumulation, wraps mod 2^16.
  function automatic logic [15:0] csum_add(input logic [15:0] acc, input logic [15:0] word);
    return acc + word;
  endfunction

endpackage

// File: rtl/sample_packer.sv
// Pairs consecutive samples into one word: first sample low byte, second high byte.
module sample_packer #(
  parameter int unsigned DataW = 8
) (
  input  logic                 i_clk_sys,
  input  logic                 i_rst,
  input  logic                 i_clear,
  input  logic                 i_valid,
  input  logic [DataW-1:0]     i_data,
  input  logic                 i_flush,
  output logic                 o_pending,
  output logic                 o_word_valid,
  output logic [2*DataW-1:0]   o_word
);

  logic               pending_q, pending_d;
  logic [DataW-1:0]   low_q, low_d;
  logic               word_valid_q, word_valid_d;
  logic [2*DataW-1:0] word_q, word_d;

  // Next-state: collect low half, complete on second sample or on flush.
  always_comb begin
    pending_d    = pending_q;
    low_d        = low_q;
    word_d       = word_q;
    word_valid_d = 1'b0;
    if (i_clear) begin
      pending_d = 1'b0;
      low_d     = '0;
    end else if (i_valid) begin
      if (!pending_q) begin
        low_d     = i_data;
        pending_d = 1'b1;
      end else begin
        word_d       = {i_data, low_q};
        word_valid_d = 1'b1;
        pending_d    = 1'b0;
      end
    end else if (i_flush && pending_q) begin
      // Odd sample count: pad the missing high half with zero.
      word_d       = {{DataW{1'b0}}, low_q};
      word_valid_d = 1'b1;
      pending_d    = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge i_clk_sys) begin
    if (i_rst) begin
      pending_q    <= 1'b0;
      low_q        <= '0;
      word_valid_q <= 1'b0;
      word_q       <= '0;
    end else begin
      pending_q    <= pending_d;
      low_q        <= low_d;
      word_valid_q <= word_valid_d;
      word_q       <= word_d;
    end
  end

  assign o_pending    = pending_q;
  assign o_word_valid = word_valid_q;
  assign o_word       = word_q;

endmodule

// File: rtl/acq_framer.sv
// Acquisition framer: delay, capture and pack ADC samples into a header/data/trailer frame.
module acq_framer
  import acq_pkg::*;
#(
  parameter int unsigned AD_W     = 8,
  parameter logic [15:0] HDR_SYNC = HDR_SYNC_DEF
) (
  input  logic            i_clk_sys,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic            i_abort,
  input  logic [15:0]     i_delay,
  input  logic [15:0]     i_len,
  input  logic            i_ad_valid,
  input  logic [AD_W-1:0] i_ad_data,
  input  logic            i_full,
  output logic            o_wr,
  output logic [15:0]     o_wr_data,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_overflow
);

  localparam logic [1:0] HdrLast = 2'(HDR_WORDS - 1);

  acq_state_e  state_q, state_d;
  logic [15:0] seq_q, seq_d;
  logic [15:0] len_q, len_d;
  logic [15:0] dly_q, dly_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  hdr_idx_q, hdr_idx_d;
  logic [15:0] csum_q, csum_d;
  logic        trail_sent_q, trail_sent_d;
  logic        wr_q, wr_d;
  logic [15:0] wr_data_q, wr_data_d;
  logic        done_q, done_d;
  logic        ovf_q, ovf_d;

  logic        pk_valid, pk_flush, pk_clear;
  logic        pk_pending, pk_word_valid;
  logic [15:0] pk_word;
  logic [15:0] hdr_word;

  sample_packer #(
    .DataW (AD_W)
  ) u_packer (
    .i_clk_sys    (i_clk_sys),
    .i_rst        (i_rst),
    .i_clear      (pk_clear),
    .i_valid      (pk_valid),
    .i_data       (i_ad_data),
    .i_flush      (pk_flush),
    .o_pending    (pk_pending),
    .o_word_valid (pk_word_valid),
    .o_word       (pk_word)
  );

  // Header word select.
  always_comb begin
    hdr_word = HDR_SYNC;
    case (hdr_idx_q)
      2'd1:    hdr_word = seq_q;
      2'd2:    hdr_word = len_q;
      default: hdr_word = HDR_SYNC;
    endcase
  end

  // FSM next-state, counters, checksum and write-port control.
  always_comb begin
    state_d      = state_q;
    seq_d        = seq_q;
    len_d        = len_q;
    dly_d        = dly_q;
    cnt_d        = cnt_q;
    hdr_idx_d    = hdr_idx_q;
    csum_d       = csum_q;
    trail_sent_d = trail_sent_q;
    wr_d         = 1'b0;
    wr_data_d    = wr_data_q;
    done_d       = 1'b0;
    ovf_d        = ovf_q;
    pk_valid     = 1'b0;
    pk_flush     = 1'b0;
    pk_clear     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          len_d        = i_len;
          dly_d        = i_delay;
          cnt_d        = i_len;
          ovf_d        = 1'b0;
          csum_d       = '0;
          hdr_idx_d    = '0;
          trail_sent_d = 1'b0;
          pk_clear     = 1'b1;
          state_d      = StHdr;
        end
      end
      StHdr: begin
        // Samples arriving here are ignored; header stalls on full.
        if (!i_full) begin
          wr_d      = 1'b1;
          wr_data_d = hdr_word;
          if (hdr_idx_q == HdrLast) begin
            state_d = (dly_q == '0) ? StCapture : StDelay;
          end else begin
            hdr_idx_d = hdr_idx_q + 2'd1;
          end
        end
      end
      StDelay: begin
        if (i_ad_valid) begin
          dly_d = dly_q - 16'd1;
          if (dly_q == 16'd1) state_d = StCapture;
        end
      end
      StCapture: begin
        if (i_ad_valid && (cnt_q != '0)) begin
          pk_valid = 1'b1;
          cnt_d    = cnt_q - 16'd1;
        end
        // ADC is never stalled: a word that meets a full FIFO is dropped.
        if (pk_word_valid) begin
          if (!i_full) begin
            wr_d      = 1'b1;
            wr_data_d = pk_word;
            csum_d    = csum_add(csum_q, pk_word);
          end else begin
            ovf_d = 1'b1;
          end
        end
        if (cnt_q == '0) begin
          if (pk_pending) begin
            pk_flush = 1'b1;
          end else if (!pk_word_valid) begin
            state_d = StTrail;
          end
        end
      end
      StTrail: begin
        // Done pulses one cycle after the trailer write, as busy falls.
        if (trail_sent_q) begin
          done_d  = 1'b1;
          seq_d   = seq_q + 16'd1;
          state_d = StIdle;
        end else if (!i_full) begin
          wr_d         = 1'b1;
          wr_data_d    = csum_q;
          trail_sent_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Abort overrides everything in a busy cycle, including a coincident start.
    if ((state_q != StIdle) && i_abort) begin
      state_d  = StIdle;
      seq_d    = seq_q;
      wr_d     = 1'b0;
      done_d   = 1'b0;
      ovf_d    = ovf_q;
      pk_valid = 1'b0;
      pk_flush = 1'b0;
      pk_clear = 1'b1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge i_clk_sys) begin
    if (i_rst) begin
      state_q      <= StIdle;
      seq_q        <= '0;
      len_q        <= '0;
      dly_q        <= '0;
      cnt_q        <= '0;
      hdr_idx_q    <= '0;
      csum_q       <= '0;
      trail_sent_q <= 1'b0;
      wr_q         <= 1'b0;
      wr_data_q    <= '0;
      done_q       <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      seq_q        <= seq_d;
      len_q        <= len_d;
      dly_q        <= dly_d;
      cnt_q        <= cnt_d;
      hdr_idx_q    <= hdr_idx_d;
      csum_q       <= csum_d;
      trail_sent_q <= trail_sent_d;
      wr_q         <= wr_d;
      wr_data_q    <= wr_data_d;
      done_q       <= done_d;
      ovf_q        <= ovf_d;
    end
  end

  assign o_wr       = wr_q;
  assign o_wr_data  = wr_data_q;
  assign o_busy     = (state_q != StIdle);
  assign o_done     = done_q;
  assign o_overflow = ovf_q;

endmodule

// File: tb/tb_acq_framer.sv
// Directed self-checking bench for acq_framer.
module tb_acq_framer;

  logic        clk;
  logic        i_rst;
  logic        i_start;
  logic        i_abort;
  logic [15:0] i_delay;
  logic [15:0] i_len;
  logic        i_ad_valid;
  logic [7:0]  i_ad_data;
  logic        i_full;
  logic        o_wr;
  logic [15:0] o_wr_data;
  logic        o_busy;
  logic        o_done;
  logic        o_overflow;

  int          n_assert = 0;
  int          n_fail   = 0;
  int          done_cnt = 0;
  int          done0    = 0;
  logic        busy_at_done = 1'b1;
  logic [15:0] wq [$];

  acq_framer dut (
    .i_clk_sys  (clk),
    .i_rst      (i_rst),
    .i_start    (i_start),
    .i_abort    (i_abort),
    .i_delay    (i_delay),
    .i_len      (i_len),
    .i_ad_valid (i_ad_valid),
    .i_ad_data  (i_ad_data),
    .i_full     (i_full),
    .o_wr       (o_wr),
    .o_wr_data  (o_wr_data),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_overflow (o_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Log every FIFO write and done pulse away from the active edge.
  always @(negedge clk) begin
    if (o_wr) wq.push_back(o_wr_data);
    if (o_done) begin
      done_cnt++;
      busy_at_done = o_busy;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [15:0] dly, input logic [15:0] len);
    wq.delete();
    done0   = done_cnt;
    i_delay = dly;
    i_len   = len;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic send_sample(input logic [7:0] d);
    i_ad_valid = 1'b1;
    i_ad_data  = d;
    tick();
    i_ad_valid = 1'b0;
    tick();
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while ((done_cnt == done0) && (k < 200)) begin
      tick();
      k++;
    end
    chk({tag, " done count"}, 32'(done_cnt - done0), 32'd1);
    chk({tag, " busy at done"}, 32'(busy_at_done), 32'd0);
  endtask

  task automatic chk_frame(input string tag, input int n,
                           input logic [15:0] w0 = 16'h0, input logic [15:0] w1 = 16'h0,
                           input logic [15:0] w2 = 16'h0, input logic [15:0] w3 = 16'h0,
                           input logic [15:0] w4 = 16'h0, input logic [15:0] w5 = 16'h0,
                           input logic [15:0] w6 = 16'h0, input logic [15:0] w7 = 16'h0);
    logic [15:0] e [8];
    e[0] = w0; e[1] = w1; e[2] = w2; e[3] = w3;
    e[4] = w4; e[5] = w5; e[6] = w6; e[7] = w7;
    chk({tag, " write count"}, 32'(wq.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s word%0d", tag, i),
          (i < wq.size()) ? 32'(wq[i]) : 32'hFFFF_FFFF, 32'(e[i]));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

  initial begin
    i_rst      = 1'b1;
    i_start    = 1'b0;
    i_abort    = 1'b0;
    i_delay    = '0;
    i_len      = '0;
    i_ad_valid = 1'b0;
    i_ad_data  = '0;
    i_full     = 1'b0;
    repeat (3) tick();
    chk("reset outputs", 32'({o_wr, o_busy, o_done, o_overflow, o_wr_data}), 32'd0);
    i_rst = 1'b0;
    tick();

    // Basic frame: delay 2, len 4, samples 01..06.
    start(16'd2, 16'd4);
    chk("basic busy after start", 32'(o_busy), 32'd1);
    repeat (4) tick();
    for (int s = 1; s <= 6; s++) send_sample(8'(s));
    wait_done("basic");
    chk_frame("basic", 6, 16'hA55A, 16'h0000, 16'h0004, 16'h0403, 16'h0605, 16'h0A08);

    // Odd length: delay 0, len 3.
    start(16'd0, 16'd3);
    repeat (4) tick();
    send_sample(8'h11);
    send_sample(8'h22);
    send_sample(8'h33);
    wait_done("odd");
    chk_frame("odd", 6, 16'hA55A, 16'h0001, 16'h0003, 16'h2211, 16'h0033, 16'h2244);

    // Full stall on header and trailer.
    start(16'd0, 16'd2);
    i_full = 1'b1;
    repeat (5) tick();
    chk("stall hdr no writes", 32'(wq.size()), 32'd0);
    i_full = 1'b0;
    repeat (4) tick();
    send_sample(8'h01);
    send_sample(8'h02);
    i_full = 1'b1;
    repeat (5) tick();
    chk("stall trail held", 32'(wq.size()), 32'd4);
    chk("stall trail no done", 32'(done_cnt - done0), 32'd0);
    i_full = 1'b0;
    wait_done("stall");
    chk_frame("stall", 5, 16'hA55A, 16'h0002, 16'h0002, 16'h0201, 16'h0201);
    chk("stall no overflow", 32'(o_overflow), 32'd0);

    // Data drop on the second data word.
    start(16'd0, 16'd8);
    repeat (4) tick();
    send_sample(8'h01);
    send_sample(8'h02);
    send_sample(8'h03);
    i_ad_valid = 1'b1;
    i_ad_data  = 8'h04;
    tick();
    i_ad_valid = 1'b0;
    i_full     = 1'b1;
    tick();
    i_full = 1'b0;
    for (int s = 5; s <= 8; s++) send_sample(8'(s));
    wait_done("drop");
    chk_frame("drop", 7, 16'hA55A, 16'h0003, 16'h0008, 16'h0201, 16'h0605, 16'h0807,
              16'h100D);
    chk("drop overflow set", 32'(o_overflow), 32'd1);

    // len 0, with an ignored start while busy; start clears overflow.
    start(16'd0, 16'd0);
    chk("len0 overflow cleared", 32'(o_overflow), 32'd0);
    i_start = 1'b1;
    i_len   = 16'd5;
    tick();
    i_start = 1'b0;
    wait_done("len0");
    repeat (5) tick();
    chk_frame("len0", 4, 16'hA55A, 16'h0004, 16'h0000, 16'h0000);

    // Abort mid-capture with a pending half-word.
    start(16'd0, 16'd6);
    repeat (4) tick();
    send_sample(8'h01);
    send_sample(8'h02);
    send_sample(8'h03);
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    chk("abort busy low", 32'(o_busy), 32'd0);
    repeat (10) tick();
    chk("abort no done", 32'(done_cnt - done0), 32'd0);
    chk_frame("abort", 4, 16'hA55A, 16'h0005, 16'h0006, 16'h0201);

    // Reset mid-header; sequence number unchanged by abort.
    start(16'd0, 16'd2);
    tick();
    chk("rst pre header word", 32'({o_wr, o_wr_data}), 32'h1_A55A);
    tick();
    chk("rst pre seq word", 32'(o_wr_data), 32'h0005);
    i_rst = 1'b1;
    tick();
    chk("rst mid outputs", 32'({o_wr, o_busy, o_done, o_overflow, o_wr_data}), 32'd0);
    i_rst = 1'b0;
    tick();

    // First frame after reset restarts the sequence at zero.
    start(16'd0, 16'd0);
    wait_done("post rst");
    chk_frame("post rst", 4, 16'hA55A, 16'h0000, 16'h0000, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/acq_framer.md
# acq_framer

Acquisition framer on the `i_clk_sys` domain, directly upstream of the USB bridge write port. After a start command it:
- skips a programmed number of ADC samples (the delay),
- packs the next `len` 8-bit samples two per 16-bit word,
- wraps them in a header/trailer frame,
- drives the bridge FIFO write interface (`o_wr`/`o_wr_data`, back-pressured by the FIFO full flag).

The command decoder supplies start, delay and length, and receives done/overflow status.

## Interface
Parameters:
- `AD_W`, 8: ADC sample width; must be 8.
- `HDR_SYNC`, 16'hA55A: first header word.

Ports:
- `i_clk_sys`  in  1: system clock; all logic single-clock.
- `i_rst`  in  1: reset, synchronous, active-high.
- `i_start`  in  1: one-cycle start pulse; ignored while `o_busy`.
- `i_abort`  in  1: one-cycle abort; returns to IDLE with no trailer.
- `i_delay`  in  16: samples to skip before capture; latched on start.
- `i_len`  in  16: samples to capture; latched on start.
- `i_ad_valid`  in  1: ADC sample strobe.
- `i_ad_data`  in  8: ADC sample.
- `i_full`  in  1: bridge FIFO full.
- `o_wr`  out  1: FIFO write strobe, registered.
- `o_wr_data`  out  16: FIFO write word, valid when `o_wr`=1.
- `o_busy`  out  1: high from the cycle after an accepted start until return to IDLE.
- `o_done`  out  1: one-cycle pulse when the trailer has been written.
- `o_overflow`  out  1: sticky; set on any dropped data word; cleared on accepted start.

## Operation
- Reset values: all outputs 0; sequence counter 0; state IDLE.
- **IDLE**: on `i_start` latch `i_delay` and `i_len`, clear `o_overflow` and the checksum, then go to HDR.
- **HDR**: emit three words in order: `HDR_SYNC`, sequence number, latched `len`.
  - One word per cycle, only in cycles with `i_full`=0; otherwise hold the word (stall).
  - ADC samples arriving during HDR are discarded and do not count toward the delay.
- **DELAY**: decrement the delay count on each `i_ad_valid`. Go to CAPTURE once the count is 0; a delay of 0 gives 0 cycles in DELAY.
- **CAPTURE**: each `i_ad_valid` sample is taken into the packer.
  - The first sample of a pair goes to the low byte, the second to the high byte.
  - On the second sample, a write is issued the following cycle.
  - If `i_full`=1 at the cycle the write is due, drop the word: no `o_wr`, set `o_overflow`, and exclude the word from the checksum. Capture continues; the ADC is never stalled.
  - The checksum is the sum of all written data words, mod 2^16.
  - After `len` samples, go to TRAIL. If `len` is odd, first emit the last word with high byte 8'h00; this word obeys the same drop rule.
  - `len`=0: no data words; go straight to TRAIL.
- **TRAIL**: emit the checksum word, stalling while `i_full`=1. Then pulse `o_done`, increment the sequence number (16-bit wrap), and go to IDLE.
- `i_abort` in any non-IDLE state: go to IDLE next cycle.
  - No trailer, no `o_done`, sequence number unchanged, `o_overflow` retained.
  - A pending packer half-word is discarded.
- `i_start` and `i_abort` in the same cycle while IDLE: start wins. While busy: abort wins, and the start is ignored.
- Reset mid-frame: everything returns to reset values at the next edge. No partial frame is completed.

## Timing
- Accepted start at edge N → `o_busy`=1 and HDR at N+1. First header `o_wr` at N+1 if `i_full`=0.
- Data latency: second sample of a pair at edge M → `o_wr` at M+1.
- At most one `o_wr` per cycle.
- `o_done` is asserted in the cycle after the trailer write, together with `o_busy` falling.
- `i_full` is sampled in the same cycle `o_wr` would assert. The bridge FIFO's full flag is conservative, so no write occurs into a full FIFO.

## Structure
- Package `acq_pkg`: `HDR_SYNC` default, state encoding (IDLE, HDR, DELAY, CAPTURE, TRAIL), header word count 3.
- Sub-module `sample_packer`: pairs 8-bit samples into 16-bit words.
  - Ports: flush (pad high byte with 0), clear, word-valid output.
- Everything else (counters, checksum, FSM) stays in `acq_framer`.

## Test plan
- **Basic frame**: delay=2, len=4, samples 01..06, `i_full`=0 → writes A55A, 0000, 0004, 0403, 0605, 0A08; `o_done` once; next frame's sequence number is 0001.
- **Odd length**: len=3, delay=0, samples 11, 22, 33 → data 2211, 0033; trailer 2244.
- **Full stall on header/trailer**: `i_full`=1 for 5 cycles during HDR → header words delayed with no loss and no `o_overflow`; same check for TRAIL.
- **Data drop**: `i_full`=1 when the second data word is due → 3 data words written instead of 4, `o_overflow`=1, checksum excludes the dropped word; the next start clears `o_overflow`.
- **Abort and reset**: `i_abort` mid-CAPTURE → IDLE next cycle, no trailer, no `o_done`, sequence number unchanged; `i_rst` mid-HDR → all outputs 0 next cycle.
- **len=0, start while busy**: len=0 → exactly 4 writes (header + trailer 0000); an `i_start` pulse during that frame is ignored.
